// File: rtl/param_code_lock_fsm_if.sv
// param_code_lock_fsm_if: keypad-side request lines and display/actuator-side status of the code lock
interface param_code_lock_fsm_if #(
  parameter int DIGITS   = 6,
  parameter int DW       = 4,
  parameter int MAX_FAIL = 3
);
  logic j, m, r;
  logic [DIGITS*DW-1:0] code_in, disp_out;
  logic res, unlocked, alarm;
  logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt;
  modport master (output j, m, r, code_in, input disp_out, res, unlocked, alarm, fail_cnt);
  modport slave (input j, m, r, code_in, output disp_out, res, unlocked, alarm, fail_cnt);
endinterface

// File: rtl/param_code_lock_fsm.sv
// param_code_lock_fsm: N-digit code lock with timed open window and failure-count alarm lockout
module param_code_lock_fsm #(
  parameter int DIGITS = 6,
  parameter int DW = 4,
  parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = '0,
  parameter int MAX_FAIL = 3,
  parameter int OPEN_CYCLES = 500,
  parameter int LOCK_CYCLES = 1000
) (
  input logic clk,
  input logic clr,
  param_code_lock_fsm_if.slave bus
);
  localparam int TMAX = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES-1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_CYCLES-1);
  localparam logic [FW-1:0] F_MAX = FW'(MAX_FAIL);
  typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;
  state_t state;
  logic [DIGITS*DW-1:0] pw;
  logic [TW-1:0] timer;
  logic j_q;
  logic jr;
  logic [FW-1:0] fail_nx;
  assign jr = bus.j & ~j_q;
  assign fail_nx = bus.fail_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      pw <= DEFAULT_CODE;
      timer <= '0;
      j_q <= 1'b0;
      bus.disp_out <= '0;
      bus.res <= 1'b0;
      bus.unlocked <= 1'b0;
      bus.alarm <= 1'b0;
      bus.fail_cnt <= '0;
    end else begin
      j_q <= bus.j;
      // stored code is only ever shown while the lock is open
      bus.disp_out <= !bus.m ? bus.code_in : state == OPEN ? pw : '1;
      case (state)
        IDLE:
          if (bus.r) begin
            pw <= DEFAULT_CODE;
            bus.fail_cnt <= '0;
            timer <= '0;
          end else if (jr && !bus.m) begin
            if (bus.code_in == pw) begin
              bus.res <= 1'b1;
              bus.fail_cnt <= '0;
              bus.unlocked <= 1'b1;
              state <= OPEN;
              timer <= T_OPEN;
            end else begin
              bus.res <= 1'b0;
              bus.fail_cnt <= fail_nx;
              if (fail_nx == F_MAX) begin
                state <= LOCKOUT;
                bus.alarm <= 1'b1;
                timer <= T_LOCK;
              end
            end
          end
        OPEN:
          if (bus.r) begin
            pw <= DEFAULT_CODE;
            bus.fail_cnt <= '0;
            timer <= '0;
            state <= IDLE;
            bus.unlocked <= 1'b0;
          end else if (jr && bus.m) begin
            pw <= bus.code_in;
            timer <= T_OPEN;
          end else if (jr || timer == '0) begin
            state <= IDLE;
            bus.unlocked <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        default:
          if (timer == '0) begin
            state <= IDLE;
            bus.alarm <= 1'b0;
            bus.fail_cnt <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
      endcase
    end
  end
endmodule
